clock_divider_bank: RTL

- Parametrised successor to the fixed-ratio clock/pulse generator: NUM_CH independent channels, each with a runtime-programmable divide ratio.
- Each channel outputs a one-cycle tick pulse and a 50%-duty square wave derived from the system clock.
- Sits beside the game/VGA timing logic and feeds slow pulses (movement, blink, debounce, score timer) to consumers in the same clk domain.
- Divider changes are glitch-free: they take effect on a channel's period boundary.

---
 rtl/clock_divider_bank.sv | 116 +++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH runtime-programmable tick/square-wave dividers.
// Optional per-channel 8-bit tick counter: define CLKDIV_TICKCNT_EN.
module clock_divider_bank #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int          SEL_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] div_pending
`ifdef CLKDIV_TICKCNT_EN
  ,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [7:0]        tick_count
`endif
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

`ifdef CLKDIV_TICKCNT_EN
  logic [7:0] tc_arr [NUM_CH];
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow_nx;
    logic             tick_q;
    logic             sq_q;
    logic             pend_q;
    logic             wr;
    logic             idle;
    logic             term;

    assign wr        = div_wr && (div_sel == SEL_W'(i));
    assign shadow_nx = wr ? div_data : shadow;
    assign idle      = !en[i] || (active == '0);
    // >= so a ratio shrunk below cnt wraps at once
    assign term      = (cnt >= active - ONE);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow <= DEF;
        active <= DEF;
        cnt    <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        shadow <= shadow_nx;
        if (sync) begin
          cnt    <= '0;
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
          active <= shadow_nx;
          pend_q <= 1'b0;
        end else if (idle) begin
          tick_q <= 1'b0;
          if (active == '0)
            cnt <= '0;
          active <= shadow_nx;
          pend_q <= 1'b0;
        end else if (term) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          sq_q   <= ~sq_q;
          active <= shadow_nx;
          pend_q <= 1'b0;
        end else begin
          cnt    <= cnt + ONE;
          tick_q <= 1'b0;
          pend_q <= pend_q | wr;
        end
      end
    end

    assign tick[i]        = tick_q;
    assign sq[i]          = sq_q;
    assign div_pending[i] = pend_q;

`ifdef CLKDIV_TICKCNT_EN
    logic [7:0] tcnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        tcnt <= '0;
      else if (sync)
        tcnt <= '0;
      else if (!idle && term)
        tcnt <= tcnt + 8'd1;
    end

    assign tc_arr[i] = tcnt;
`endif
  end

`ifdef CLKDIV_TICKCNT_EN
  always_comb begin
    tick_count = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cnt_sel == SEL_W'(k))
        tick_count = tc_arr[k];
  end
`endif

endmodule
